// File: rtl/counter_pkg.sv
// counter_pkg: mode constants and load-value clamping shared by the modulus counter.
package counter_pkg;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic int unsigned clamp_mod(input int unsigned value, input int unsigned m);
        return (value >= m) ? m - 1 : value;
    endfunction
endpackage

// File: rtl/tff_cell.sv
// tff_cell: T flip-flop with async clear, sync clear/load override, toggle input.
module tff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic CLK,
    input  logic CLR,
    input  logic SCLR,
    input  logic LD,
    input  logic D,
    input  logic T,
    output logic Q,
    output logic NQ
);
    always_ff @(posedge CLK or posedge CLR)
        if (CLR) Q <= RST_BIT;
        else if (SCLR) Q <= 1'b0;
        else if (LD) Q <= D;
        else if (T) Q <= ~Q;

    assign NQ = ~Q;
endmodule

// File: rtl/mod_counter.sv
// mod_counter: up/down modulus counter with load, sync clear, wrap/saturate and cascade outputs.
module mod_counter
    import counter_pkg::*;
#(
    parameter int W       = 4,
    parameter int MOD     = 16,
    parameter int SAT     = MODE_WRAP,
    parameter int RST_VAL = 0
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         EN,
    input  logic         SCLR,
    input  logic         UP,
    input  logic         LD,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         TC,
    output logic         WRAP
);
    localparam logic [W-1:0] TOP = W'(MOD - 1);
    localparam logic IS_SAT = (SAT == MODE_SAT);

    if (MOD < 2 || longint'(MOD) > (longint'(1) << W) || RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_params
        $error("mod_counter: illegal MOD or RST_VAL for width W");
    end

    logic [W-1:0] nq, ld_val, cnt_nxt, tgl;
    logic at_top, at_zero;

    assign at_top  = (Q == TOP);
    assign at_zero = &nq;
    assign TC      = EN & (UP ? at_top : at_zero);
    assign ld_val  = W'(clamp_mod(32'(D), 32'(MOD)));

    always_comb begin
        cnt_nxt = UP ? (at_top ? (IS_SAT ? Q : '0) : Q + W'(1))
                     : (at_zero ? (IS_SAT ? Q : TOP) : Q - W'(1));
        tgl = EN ? (Q ^ cnt_nxt) : '0;
    end

    // each cell flips exactly the bits that differ between the count and its successor
    for (genvar i = 0; i < W; i++) begin : g_cell
        tff_cell #(.RST_BIT(1'((RST_VAL >> i) & 1))) u_cell (
            .CLK (CLK),
            .CLR (CLR),
            .SCLR(SCLR),
            .LD  (LD),
            .D   (ld_val[i]),
            .T   (tgl[i]),
            .Q   (Q[i]),
            .NQ  (nq[i])
        );
    end

    always_ff @(posedge CLK or posedge CLR)
        if (CLR) WRAP <= 1'b0;
        else WRAP <= TC & ~SCLR & ~LD & ~IS_SAT;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed and randomized checks of mod_counter against an integer model.
module tb_mod_counter;
    logic CLK = 1'b0;
    logic CLR, EN, SCLR, UP, LD, cen;
    logic [3:0] D;
    logic [3:0] q_r, q_w, q_s, q_c0, q_c1;
    logic tc_r, tc_w, tc_s, tc_c0, tc_c1;
    logic wrap_r, wrap_w, wrap_s, wrap_c0, wrap_c1;

    int total = 0;
    int bad = 0;
    int mr, mw, ms;
    bit xr, xw, xs;

    always #5 CLK = ~CLK;

    mod_counter #(.W(4), .MOD(16), .SAT(0), .RST_VAL(5)) u_r (
        .CLK(CLK), .CLR(CLR), .EN(EN), .SCLR(SCLR), .UP(UP), .LD(LD), .D(D),
        .Q(q_r), .TC(tc_r), .WRAP(wrap_r));
    mod_counter #(.W(4), .MOD(10), .SAT(0), .RST_VAL(0)) u_w (
        .CLK(CLK), .CLR(CLR), .EN(EN), .SCLR(SCLR), .UP(UP), .LD(LD), .D(D),
        .Q(q_w), .TC(tc_w), .WRAP(wrap_w));
    mod_counter #(.W(4), .MOD(12), .SAT(1), .RST_VAL(0)) u_s (
        .CLK(CLK), .CLR(CLR), .EN(EN), .SCLR(SCLR), .UP(UP), .LD(LD), .D(D),
        .Q(q_s), .TC(tc_s), .WRAP(wrap_s));
    mod_counter #(.W(4), .MOD(10), .SAT(0), .RST_VAL(0)) u_c0 (
        .CLK(CLK), .CLR(CLR), .EN(cen), .SCLR(SCLR), .UP(UP), .LD(1'b0), .D(4'd0),
        .Q(q_c0), .TC(tc_c0), .WRAP(wrap_c0));
    mod_counter #(.W(4), .MOD(10), .SAT(0), .RST_VAL(0)) u_c1 (
        .CLK(CLK), .CLR(CLR), .EN(tc_c0), .SCLR(SCLR), .UP(UP), .LD(1'b0), .D(4'd0),
        .Q(q_c1), .TC(tc_c1), .WRAP(wrap_c1));

    function automatic int nxt(input int q, input int m, input bit sat);
        if (SCLR) return 0;
        if (LD) return (int'(D) > m - 1) ? m - 1 : int'(D);
        if (!EN) return q;
        if (UP) return sat ? ((q + 1 > m - 1) ? m - 1 : q + 1) : (q + 1) % m;
        return sat ? ((q == 0) ? 0 : q - 1) : (q + m - 1) % m;
    endfunction

    function automatic bit wr(input int q, input int m, input bit sat);
        return !SCLR && !LD && EN && !sat && (UP ? q == m - 1 : q == 0);
    endfunction

    function automatic bit tc_exp(input int q, input int m);
        return EN && (UP ? q == m - 1 : q == 0);
    endfunction

    task automatic tick;
        if (CLR) begin
            mr = 5; mw = 0; ms = 0; xr = 0; xw = 0; xs = 0;
        end else begin
            xr = wr(mr, 16, 0); mr = nxt(mr, 16, 0);
            xw = wr(mw, 10, 0); mw = nxt(mw, 10, 0);
            xs = wr(ms, 12, 1); ms = nxt(ms, 12, 1);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        CLR = 1; EN = 0; SCLR = 0; UP = 1; LD = 0; D = 0; cen = 0;
        tick; tick;
        CLR = 0; EN = 1;
        tick; tick; tick;
        total++;
        if (q_r !== 4'd8) begin bad++; $display("FAIL reset_count: got %0d want 8", q_r); end
        #2 CLR = 1;
        #1;
        total++;
        if (q_r !== 4'd5) begin bad++; $display("FAIL reset_async_q: got %0d want 5", q_r); end
        total++;
        if (wrap_r !== 1'b0) begin bad++; $display("FAIL reset_async_wrap: got %0d want 0", wrap_r); end
        total++;
        if (q_w !== 4'd0) begin bad++; $display("FAIL reset_async_qw: got %0d want 0", q_w); end
        mr = 5; mw = 0; ms = 0; xr = 0; xw = 0; xs = 0;
        CLR = 0;
        tick;
        total++;
        if (q_r !== 4'd6) begin bad++; $display("FAIL reset_release: got %0d want 6", q_r); end
    endtask

    task automatic test_up_wrap;
        SCLR = 1; EN = 0; tick;
        SCLR = 0; EN = 1; UP = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++;
            if (tc_w !== (i % 10 == 9)) begin bad++; $display("FAIL up_tc[%0d]: got %0d want %0d", i, tc_w, i % 10 == 9); end
            tick;
            total++;
            if (q_w !== 4'((i + 1) % 10)) begin bad++; $display("FAIL up_q[%0d]: got %0d want %0d", i, q_w, (i + 1) % 10); end
            total++;
            if (wrap_w !== (i % 10 == 9)) begin bad++; $display("FAIL up_wrap[%0d]: got %0d want %0d", i, wrap_w, i % 10 == 9); end
        end
    endtask

    task automatic test_down_wrap;
        int exp_q[3] = '{0, 9, 8};
        bit exp_tc[3] = '{0, 1, 0};
        bit exp_wr[3] = '{0, 1, 0};
        LD = 1; D = 1; EN = 0; tick;
        total++;
        if (q_w !== 4'd1) begin bad++; $display("FAIL down_load: got %0d want 1", q_w); end
        LD = 0; EN = 1; UP = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (tc_w !== exp_tc[i]) begin bad++; $display("FAIL down_tc[%0d]: got %0d want %0d", i, tc_w, exp_tc[i]); end
            tick;
            total++;
            if (q_w !== 4'(exp_q[i])) begin bad++; $display("FAIL down_q[%0d]: got %0d want %0d", i, q_w, exp_q[i]); end
            total++;
            if (wrap_w !== exp_wr[i]) begin bad++; $display("FAIL down_wrap[%0d]: got %0d want %0d", i, wrap_w, exp_wr[i]); end
        end
    endtask

    task automatic test_saturate;
        SCLR = 1; EN = 0; tick;
        SCLR = 0; EN = 1; UP = 1;
        for (int i = 0; i < 20; i++) begin
            tick;
            total++;
            if (wrap_s !== 1'b0) begin bad++; $display("FAIL sat_wrap[%0d]: got %0d want 0", i, wrap_s); end
        end
        total++;
        if (q_s !== 4'd11) begin bad++; $display("FAIL sat_hold: got %0d want 11", q_s); end
        #1;
        total++;
        if (tc_s !== 1'b1) begin bad++; $display("FAIL sat_tc: got %0d want 1", tc_s); end
        UP = 0; tick;
        total++;
        if (q_s !== 4'd10) begin bad++; $display("FAIL sat_down: got %0d want 10", q_s); end
    endtask

    task automatic test_priority;
        SCLR = 1; LD = 1; EN = 1; D = 5; tick;
        total++;
        if (q_w !== 4'd0) begin bad++; $display("FAIL prio_sclr: got %0d want 0", q_w); end
        SCLR = 0; D = 14; tick;
        total++;
        if (q_w !== 4'd9) begin bad++; $display("FAIL prio_clamp: got %0d want 9", q_w); end
        total++;
        if (q_s !== 4'd11) begin bad++; $display("FAIL prio_clamp_s: got %0d want 11", q_s); end
        EN = 0; D = 3; tick;
        total++;
        if (q_w !== 4'd3) begin bad++; $display("FAIL prio_load_noen: got %0d want 3", q_w); end
        LD = 0;
    endtask

    task automatic test_cascade;
        int n = 0;
        int prev;
        int pair;
        EN = 0; LD = 0; UP = 1; SCLR = 1; tick;
        SCLR = 0; cen = 1;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            #1;
            total++;
            if (tc_c1 !== (n == 99)) begin bad++; $display("FAIL casc_tc[%0d]: got %0d want %0d", cyc, tc_c1, n == 99); end
            tick;
            prev = n;
            n = (n + 1) % 100;
            pair = int'(q_c1) * 10 + int'(q_c0);
            total++;
            if (pair !== n) begin bad++; $display("FAIL casc_pair[%0d]: got %0d want %0d", cyc, pair, n); end
            total++;
            if (wrap_c0 !== (prev % 10 == 9)) begin bad++; $display("FAIL casc_wrap0[%0d]: got %0d want %0d", cyc, wrap_c0, prev % 10 == 9); end
            total++;
            if (wrap_c1 !== (prev == 99)) begin bad++; $display("FAIL casc_wrap1[%0d]: got %0d want %0d", cyc, wrap_c1, prev == 99); end
            if (cyc == 49 || cyc == 149) begin
                total++;
                if (pair !== 49) begin bad++; $display("FAIL casc_49[%0d]: got %0d want 49", cyc, pair); end
            end
        end
        cen = 0;
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            CLR  = ($urandom % 64) == 0;
            SCLR = ($urandom % 16) == 0;
            LD   = ($urandom % 8) == 0;
            EN   = ($urandom % 4) != 0;
            UP   = 1'($urandom % 2);
            D    = 4'($urandom % 16);
            #1;
            if (!CLR) begin
                total++;
                if ({tc_r, tc_w, tc_s} !== {tc_exp(mr, 16), tc_exp(mw, 10), tc_exp(ms, 12)}) begin
                    bad++; $display("FAIL rand_tc[%0d]: got %b want %b", i, {tc_r, tc_w, tc_s}, {tc_exp(mr, 16), tc_exp(mw, 10), tc_exp(ms, 12)});
                end
            end
            tick;
            total++;
            if (q_r !== 4'(mr) || q_w !== 4'(mw) || q_s !== 4'(ms)) begin
                bad++; $display("FAIL rand_q[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i, q_r, q_w, q_s, mr, mw, ms);
            end
            total++;
            if ({wrap_r, wrap_w, wrap_s} !== {xr, xw, xs}) begin
                bad++; $display("FAIL rand_wrap[%0d]: got %b want %b", i, {wrap_r, wrap_w, wrap_s}, {xr, xw, xs});
            end
        end
        CLR = 0;
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_wrap;
        test_saturate;
        test_priority;
        test_cascade;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised synchronous up/down counter with modulus, parallel load, synchronous clear, and wrap or saturate mode.
- Successor to the fixed 4-bit T-cell counter: any width, any modulus, bidirectional counting and cascade outputs.
- Used directly on board I/O (switch-driven enable and direction, key-driven clock) or chained to build multi-digit counters, e.g. BCD with MOD=10.

Parameters:
- W, 4, counter width in bits.
- MOD, 16, count range 0..MOD-1; legal range 2 <= MOD <= 2**W.
- SAT, 0, 0 = wrap at terminal value, 1 = saturate (hold) at terminal value.
- RST_VAL, 0, value loaded by CLR; must be < MOD.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- CLR  input  1  reset, asynchronous, active-high; forces Q=RST_VAL and WRAP=0 immediately.
- EN  input  1  count enable.
- SCLR  input  1  synchronous clear to 0.
- UP  input  1  direction: 1 = increment, 0 = decrement.
- LD  input  1  synchronous parallel load.
- D  input  W  load value.
- Q  output  W  current count.
- TC  output  1  terminal count, combinational: EN & (UP ? Q==MOD-1 : Q==0).
- WRAP  output  1  registered one-cycle pulse when the count wrapped on the previous edge.

Behaviour:
- While CLR=1: Q=RST_VAL, WRAP=0 asynchronously, regardless of CLK. Deassertion takes effect at the next rising edge; no count occurs on an edge where CLR is still high.
- Per rising edge, highest priority first:
  1. SCLR=1: Q<=0, WRAP<=0.
  2. LD=1: Q<=min(D, MOD-1), i.e. out-of-range loads clamp to MOD-1; WRAP<=0.
  3. EN=1, UP=1: if Q==MOD-1, then SAT=0 gives Q<=0, WRAP<=1; SAT=1 gives Q holds, WRAP<=0. Otherwise Q<=Q+1, WRAP<=0.
  4. EN=1, UP=0: if Q==0, then SAT=0 gives Q<=MOD-1, WRAP<=1; SAT=1 gives Q holds, WRAP<=0. Otherwise Q<=Q-1, WRAP<=0.
  5. EN=0: Q holds, WRAP<=0.
- SCLR and LD act regardless of EN.
- Latency:
  - Q updates one edge after the qualifying inputs.
  - WRAP is high exactly one cycle, in the cycle after the wrapping edge.
  - TC has zero latency.
- Cascading:
  - Feed TC of stage n into EN of stage n+1, same CLK and UP. This gives a synchronous ripple-enable chain like the T-cell chain.
  - TC stays asserted in SAT mode while held at the terminal value.
- UP may change on any cycle; the new direction applies on that edge.
- Arithmetic is modulo MOD, not modulo 2**W. Q never leaves 0..MOD-1 after reset.
- Elaboration must fail if MOD < 2, MOD > 2**W, or RST_VAL >= MOD.

Decomposition:
- Shared package counter_pkg holds the mode constants MODE_WRAP=0 and MODE_SAT=1, plus a function clamp_mod(value, MOD).
- One sub-module, tff_cell: a single T flip-flop with async CLR, sync SCLR/LD override, toggle input, Q and NQ outputs.
- mod_counter instantiates W tff_cell instances and computes per-bit toggle terms for up/down, wrap and saturate in its own combinational logic.

Test Plan:
- Reset: W=4, MOD=16, RST_VAL=5. Assert CLR mid-count with CLK idle -> Q=5 and WRAP=0 immediately; release CLR, EN=1, UP=1 -> Q=6 after the first edge.
- Up wrap: MOD=10, SAT=0, UP=1, EN=1 from Q=0 -> Q runs 0..9 then 0. TC=1 only while Q=9. WRAP=1 for exactly the one cycle after 9 -> 0.
- Down wrap: MOD=10, SAT=0, UP=0, LD D=1 then EN=1 -> Q runs 1, 0, 9. TC=1 at Q=0. WRAP pulses once.
- Saturate: MOD=12, SAT=1, UP=1, EN=1 for 20 cycles -> Q stops at 11, TC stays 1, WRAP never asserts. Flip UP=0 -> Q=10 on the next edge.
- Priority and clamp: MOD=10, W=4, SCLR=1, LD=1, EN=1 on the same edge -> Q=0. Then LD=1, D=14 -> Q=9. LD=1, EN=0 -> load still occurs.
- Cascade: two MOD=10 stages, stage-1 EN=TC of stage 0, run 150 cycles from 0 -> the {stage1,stage0} pair steps 00..99 then back to 00. Pairs read 49 at cycle 49 and 49 again at cycle 149; stage 1 advances only on stage-0 9 -> 0 edges.
